rv_rr_arb: RTL and testbench



---
 rtl/rv_pkg.sv | 11 +
 rtl/rr_pick.sv | 31 +++
 rtl/rv_rr_arb.sv | 87 ++++++++
 tb/tb_rv_rr_arb.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared helpers and constants for ready/valid blocks
package rv_pkg;

  localparam int DEF_DW = 32;

  // Index width that stays at least one bit wide even for a single requester
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick: first set req at or after ptr, mod N
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          hit,
  output logic [IW-1:0] gnt_idx
);

  // Scan from the farthest offset back to ptr so the nearest request wins
  always_comb begin
    int idx;
    logic [IW-1:0] sel;
    idx     = 0;
    sel     = '0;
    hit     = 1'b0;
    gnt_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      sel = IW'(idx);
      if (req[sel]) begin
        hit     = 1'b1;
        gnt_idx = sel;
      end
    end
  end

endmodule

// File: rtl/rv_rr_arb.sv
// rtl/rv_rr_arb.sv - N-way round-robin ready/valid arbiter into one registered slot
// Define RV_RR_ARB_SVA_EN to compile in the embedded protocol assertions.
module rv_rr_arb
  import rv_pkg::*;
#(
  parameter int N  = 4,
  parameter int DW = DEF_DW,
  parameter int IW = idx_w(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  in_valid,
  output logic [N-1:0]  in_ready,
  input  logic [N*DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [IW-1:0] out_id
);

  logic          full;
  logic [DW-1:0] data_q;
  logic [IW-1:0] id_q;
  logic [IW-1:0] ptr;
  logic [IW-1:0] gnt;
  logic          hit;
  logic          accept;
  logic          push;
  logic          pop;

  rr_pick #(.N(N), .IW(IW)) u_pick (
    .req     (in_valid),
    .ptr     (ptr),
    .hit     (hit),
    .gnt_idx (gnt)
  );

  // Slot can take a new word when empty or when it is draining this cycle
  assign accept = !full || out_ready;
  assign push   = !rst && accept && hit;
  assign pop    = full && out_ready;

  always_comb begin
    in_ready = '0;
    if (push) in_ready[gnt] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full   <= 1'b0;
      data_q <= '0;
      id_q   <= '0;
      ptr    <= '0;
    end else if (push) begin
      full   <= 1'b1;
      data_q <= in_data[gnt*DW +: DW];
      id_q   <= gnt;
      ptr    <= (gnt == IW'(N - 1)) ? '0 : gnt + IW'(1);
    end else if (pop) begin
      full   <= 1'b0;
    end
  end

  assign out_valid = full;
  assign out_data  = data_q;
  assign out_id    = id_q;

`ifdef RV_RR_ARB_SVA_EN
  a_stall_stable: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> ($stable(out_valid) && $stable(out_data) && $stable(out_id)))
    else $error("rv_rr_arb: output changed while stalled");

  a_ready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(in_ready))
    else $error("rv_rr_arb: in_ready not one-hot");

  a_ptr_range: assert property (@(posedge clk) disable iff (rst) (int'(ptr) < N))
    else $error("rv_rr_arb: ptr out of range");

  for (genvar i = 0; i < N; i++) begin : g_in_hold
    a_in_hold: assert property (@(posedge clk) disable iff (rst)
      (in_valid[i] && !in_ready[i]) |=> (in_valid[i] && $stable(in_data[i*DW +: DW])))
      else $error("rv_rr_arb: requester %0d withdrew or changed a pending request", i);
  end
`else
`endif

endmodule

// File: tb/tb_rv_rr_arb.sv
// tb/tb_rv_rr_arb.sv - self-checking bench for rv_rr_arb with per-requester scoreboard
module tb_rv_rr_arb;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [N*DW-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic [IW-1:0]   out_id;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          expq[$];
  logic [DW-1:0] sbq[N][$];

  always #5 clk = ~clk;

  rv_rr_arb #(.N(N), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [DW-1:0] d);
    in_valid[i] = v;
    in_data[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = '0;
    in_data = '0;
    out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 32'hA0 + i);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      @(negedge clk);
      total += 3;
      if (in_ready !== '0) begin bad++; $display("FAIL reset_in_ready: got %b want 0000", in_ready); end
      if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      if (out_id !== '0) begin bad++; $display("FAIL reset_out_id: got %0d want 0", out_id); end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (in_ready !== 4'b0001) begin bad++; $display("FAIL reset_first_grant: got %b want 0001", in_ready); end
    step();
    @(negedge clk);
    total += 3;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL reset_first_valid: got %b want 1", out_valid); end
    if (out_id !== 2'd0) begin bad++; $display("FAIL reset_first_id: got %0d want 0", out_id); end
    if (out_data !== 32'hA0) begin bad++; $display("FAIL reset_first_data: got %h want a0", out_data); end
  endtask

  task automatic test_round_robin();
    exp_t e;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 32'hA0 + i);
    expq.delete();
    for (int n = 0; n < 8; n++) begin
      e.id = IW'(n % N);
      e.data = 32'hA0 + (n % N);
      expq.push_back(e);
    end
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (k > 0) begin
        total++;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL rr_throughput: cycle %0d out_valid got %b want 1", k, out_valid); end
      end
      if (out_valid === 1'b1 && out_ready) begin
        total += 2;
        if (expq.size() == 0) begin
          bad += 2;
          $display("FAIL rr_extra: got id %0d with nothing expected", out_id);
        end else begin
          e = expq.pop_front();
          if (out_id !== e.id) begin bad++; $display("FAIL rr_id: got %0d want %0d", out_id, e.id); end
          if (out_data !== e.data) begin bad++; $display("FAIL rr_data: got %h want %h", out_data, e.data); end
        end
      end
      step();
    end
    total++;
    if (expq.size() != 0) begin bad++; $display("FAIL rr_missing: got %0d left want 0", expq.size()); end
    in_valid = '0;
  endtask

  task automatic test_stall();
    do_reset();
    out_ready = 1'b0;
    set_req(2, 1'b1, 32'h1234);
    @(negedge clk);
    total++;
    if (in_ready !== 4'b0100) begin bad++; $display("FAIL stall_first_grant: got %b want 0100", in_ready); end
    step();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total += 4;
      if (out_valid !== 1'b1) begin bad++; $display("FAIL stall_valid: got %b want 1", out_valid); end
      if (out_data !== 32'h1234) begin bad++; $display("FAIL stall_data: got %h want 1234", out_data); end
      if (out_id !== 2'd2) begin bad++; $display("FAIL stall_id: got %0d want 2", out_id); end
      if (in_ready !== 4'b0000) begin bad++; $display("FAIL stall_in_ready: got %b want 0000", in_ready); end
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 4'b0100) begin bad++; $display("FAIL stall_release_grant: got %b want 0100", in_ready); end
    step();
    set_req(2, 1'b0, '0);
    @(negedge clk);
    total += 2;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL stall_refill_valid: got %b want 1", out_valid); end
    if (out_id !== 2'd2) begin bad++; $display("FAIL stall_refill_id: got %0d want 2", out_id); end
    step();
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_empty: got %b want 0", out_valid); end
  endtask

  task automatic test_wrap_skip();
    do_reset();
    out_ready = 1'b1;
    set_req(2, 1'b1, 32'h22);
    @(negedge clk);
    total++;
    if (in_ready !== 4'b0100) begin bad++; $display("FAIL wrap_seed: got %b want 0100", in_ready); end
    step();
    set_req(2, 1'b0, '0);
    set_req(1, 1'b1, 32'h31);
    set_req(3, 1'b1, 32'h33);
    @(negedge clk);
    total++;
    if (in_ready !== 4'b1000) begin bad++; $display("FAIL wrap_grant3: got %b want 1000", in_ready); end
    step();
    set_req(3, 1'b1, 32'h34);
    @(negedge clk);
    total += 3;
    if (in_ready !== 4'b0010) begin bad++; $display("FAIL wrap_grant1: got %b want 0010", in_ready); end
    if (out_id !== 2'd3) begin bad++; $display("FAIL wrap_id3: got %0d want 3", out_id); end
    if (out_data !== 32'h33) begin bad++; $display("FAIL wrap_data33: got %h want 33", out_data); end
    step();
    set_req(1, 1'b0, '0);
    @(negedge clk);
    total += 3;
    if (in_ready !== 4'b1000) begin bad++; $display("FAIL wrap_grant3b: got %b want 1000", in_ready); end
    if (out_id !== 2'd1) begin bad++; $display("FAIL wrap_id1: got %0d want 1", out_id); end
    if (out_data !== 32'h31) begin bad++; $display("FAIL wrap_data31: got %h want 31", out_data); end
    step();
    set_req(3, 1'b0, '0);
    @(negedge clk);
    total += 2;
    if (out_id !== 2'd3) begin bad++; $display("FAIL wrap_id3b: got %0d want 3", out_id); end
    if (out_data !== 32'h34) begin bad++; $display("FAIL wrap_data34: got %h want 34", out_data); end
    step();
  endtask

  task automatic test_push_pop();
    do_reset();
    out_ready = 1'b0;
    set_req(0, 1'b1, 32'h11);
    @(negedge clk);
    total++;
    if (in_ready !== 4'b0001) begin bad++; $display("FAIL pp_fill: got %b want 0001", in_ready); end
    step();
    set_req(0, 1'b0, '0);
    set_req(1, 1'b1, 32'h22);
    out_ready = 1'b1;
    @(negedge clk);
    total += 3;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL pp_full: got %b want 1", out_valid); end
    if (out_data !== 32'h11) begin bad++; $display("FAIL pp_old_data: got %h want 11", out_data); end
    if (in_ready !== 4'b0010) begin bad++; $display("FAIL pp_accept: got %b want 0010", in_ready); end
    step();
    set_req(1, 1'b0, '0);
    @(negedge clk);
    total += 3;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL pp_stay_valid: got %b want 1", out_valid); end
    if (out_data !== 32'h22) begin bad++; $display("FAIL pp_new_data: got %h want 22", out_data); end
    if (out_id !== 2'd1) begin bad++; $display("FAIL pp_new_id: got %0d want 1", out_id); end
    step();
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL pp_drained: got %b want 0", out_valid); end
  endtask

  task automatic test_soak();
    logic          m_full;
    logic [IW-1:0] m_id;
    int            m_ptr;
    int            seq;
    int            g;
    int            grant_i;
    logic [N-1:0]  exp_rdy;
    logic [DW-1:0] d;
    do_reset();
    for (int i = 0; i < N; i++) sbq[i].delete();
    m_full = 1'b0;
    m_id = '0;
    m_ptr = 0;
    seq = 0;
    for (int cyc = 0; cyc < 320; cyc++) begin
      if (cyc < 300) begin
        for (int i = 0; i < N; i++) begin
          if (!in_valid[i] && $urandom_range(0, 99) < 70) begin
            d = {8'(i), 24'(seq)};
            seq++;
            set_req(i, 1'b1, d);
            sbq[i].push_back(d);
          end
        end
        out_ready = 1'($urandom_range(0, 1));
      end else begin
        out_ready = 1'b1;
      end
      @(negedge clk);
      g = pick(in_valid, m_ptr);
      exp_rdy = ((!m_full || out_ready) && g >= 0) ? N'(1 << g) : '0;
      total += 2;
      if (in_ready !== exp_rdy) begin bad++; $display("FAIL soak_in_ready: cycle %0d got %b want %b", cyc, in_ready, exp_rdy); end
      if (out_valid !== m_full) begin bad++; $display("FAIL soak_out_valid: cycle %0d got %b want %b", cyc, out_valid, m_full); end
      if (m_full && out_ready) begin
        total += 2;
        if (out_id !== m_id) begin bad++; $display("FAIL soak_out_id: cycle %0d got %0d want %0d", cyc, out_id, m_id); end
        if (sbq[m_id].size() == 0) begin
          bad++;
          $display("FAIL soak_extra: cycle %0d got %h with nothing queued for %0d", cyc, out_data, m_id);
        end else begin
          d = sbq[m_id].pop_front();
          if (out_data !== d) begin bad++; $display("FAIL soak_data: cycle %0d got %h want %h", cyc, out_data, d); end
        end
      end
      grant_i = -1;
      if (exp_rdy != '0) begin
        m_full = 1'b1;
        m_id = IW'(g);
        m_ptr = (g + 1) % N;
        grant_i = g;
      end else if (m_full && out_ready) begin
        m_full = 1'b0;
      end
      step();
      if (grant_i >= 0) set_req(grant_i, 1'b0, '0);
    end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL soak_drain_valid: got %b want 0", out_valid); end
    for (int i = 0; i < N; i++) begin
      total++;
      if (sbq[i].size() != 0) begin bad++; $display("FAIL soak_lost: requester %0d got %0d undelivered want 0", i, sbq[i].size()); end
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = '0;
    in_data = '0;
    out_ready = 1'b0;
    test_reset();
    test_round_robin();
    test_stall();
    test_wrap_skip();
    test_push_pop();
    test_soak();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
